bt_uart_rx: RTL
===============

Name: bt_uart_rx

Overview:
- UART 8N1 receiver for the Bluetooth module's TX line.
- It is the return path paired with the Bluetooth initializer. The initializer drives Key and raises init_flag. This block then listens for the module's replies.
- It delivers each received byte with a single-cycle valid strobe.
- It can optionally detect the AT acknowledgement string "OK\r\n" and report a link-ready pulse to the command handler.

Parameters:
- CLKS_PER_BIT, default 5208: clk cycles per UART bit (50 MHz / 9600 baud). Minimum 4.
- CNT_W, default 13: width of the bit-timing counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset. Synchronous, active-low; clock clk.
- init_flag  in  1  receiver enable; comes from the initializer's init_flag
- rxd  in  1  asynchronous serial input from the module TX pin; idles high
- rx_data  out  8  last correctly received byte
- rx_valid  out  1  one-cycle strobe: rx_data has just been updated
- frame_err  out  1  one-cycle strobe: the stop bit was sampled low
- busy  out  1  high in every state other than IDLE
- ok_pulse  out  1  one-cycle strobe: "OK\r\n" completed. Present only with the optional feature; otherwise tied to 0.

Behaviour:
- Reset values:
  - rx_data=8'h00; rx_valid=0; frame_err=0; busy=0; ok_pulse=0.
  - Both synchronizer flops reset to 1.
  - State=IDLE; counters=0.
- rxd passes through a 2-flop synchronizer. All logic below uses the synchronized value rxs.
- FSM states and transitions:
  - IDLE: when rxs==0, go to START and set cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1 (integer divide), sample rxs.
    - rxs==0: go to DATA; cnt=0; bit_idx=0.
    - rxs==1: glitch; return to IDLE with no strobe.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rxs into the shift register (LSB first) and set cnt=0.
    - After bit_idx==7 is sampled, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs.
    - rxs==1: rx_data<=shift; rx_valid=1 for one cycle.
    - rxs==0: frame_err=1 for one cycle; rx_data unchanged.
    - In both cases, go to IDLE.
- All sampling instants are mid-bit.
- Timing of rx_valid: falling edge at rxd + 2 sync cycles + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge arriving right after the stop bit is accepted. There is no required idle gap.
- init_flag==0:
  - FSM is forced to IDLE; cnt=0; bit_idx=0.
  - No strobes are issued and the matcher is cleared.
  - If init_flag drops mid-frame, the frame is aborted silently.
- Line held low (break):
  - The first frame ends in frame_err.
  - The block then waits in IDLE. IDLE re-arms on rxs==0, so a held-low line yields repeated frame_err strobes, one per frame time.
- Reset mid-frame: everything returns to reset values on the next clk edge.
- Strobes are never high in two consecutive cycles. rx_valid and frame_err are mutually exclusive.

Optional Feature:
- Macro: BT_UART_RX_OK_MATCH_EN.
- With the macro defined, a matcher tracks progress (0..3) through the sequence 'O'(8'h4F), 'K'(8'h4B), CR(8'h0D), LF(8'h0A).
  - On rx_valid with the expected byte: progress advances.
  - On completion (LF accepted at progress 3): ok_pulse=1 on the following cycle, and progress returns to 0.
  - On a mismatch: progress becomes 1 if the byte is 'O', otherwise 0.
  - frame_err clears progress to 0.
- Without the macro: ok_pulse is constant 0 and no matcher logic is generated.

Decomposition:
- Package bt_pkg holds:
  - the state enum {IDLE, START, DATA, STOP} (2 bits);
  - localparams BT_ASCII_O, BT_ASCII_K, BT_ASCII_CR, BT_ASCII_LF.
- Sub-module bt_ok_matcher takes clk, rst_n, clr, byte_in, byte_vld and outputs ok_pulse. It is instantiated only under the macro.

Test Plan (CLKS_PER_BIT=16):
- Single byte: init_flag=1; send 0xA5 as 8N1 → exactly one rx_valid; rx_data=0xA5; frame_err stays 0; rx_valid occurs 2+8+144+1 = 155 cycles after the start-edge cycle, ±1.
- Glitch: rxd low for 4 cycles, then high → busy pulses, returns to IDLE; no rx_valid and no frame_err.
- Framing error: send 0x3C with the stop bit low → frame_err pulses once; rx_data keeps its previous value; the next valid byte 0x55 is received correctly.
- Disable: drive a frame of 0x12 with init_flag=0 → no strobes, busy=0. Raise init_flag mid-way through a second frame, then send 0x34 cleanly → only 0x34 is reported.
- Back-to-back: send 0x00, 0xFF, 0x81 with no idle gap → three rx_valid strobes in order with matching data.
- Optional feature (macro defined): send "OOK\r\n", then "OK\rX" → exactly one ok_pulse, one cycle after the rx_valid for LF; none for the second sequence.

Source files
------------

// File: rtl/bt_pkg.sv
// ---------------------------------------------------------------------------
// bt_pkg
// Shared types and constants for the Bluetooth UART receive path.
//   rxState_t        : receiver FSM state encoding (2 bits)
//   BT_ASCII_*       : bytes of the AT acknowledgement string "OK\r\n"
// ---------------------------------------------------------------------------
package bt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rxState_t;

   localparam logic [7:0] BT_ASCII_O  = 8'h4F;
   localparam logic [7:0] BT_ASCII_K  = 8'h4B;
   localparam logic [7:0] BT_ASCII_CR = 8'h0D;
   localparam logic [7:0] BT_ASCII_LF = 8'h0A;

endpackage

// File: rtl/bt_ok_matcher.sv
// ---------------------------------------------------------------------------
// bt_ok_matcher
// Tracks received bytes against the sequence 'O','K',CR,LF and pulses
// ok_pulse for one cycle, the cycle after the LF byte is accepted.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clr          : clears match progress (receiver disabled / framing error)
//   byte_in      : received byte, qualified by byte_vld
//   byte_vld     : one-cycle strobe, byte_in is new
//   ok_pulse     : one-cycle strobe, "OK\r\n" completed
// ---------------------------------------------------------------------------
module bt_ok_matcher
   import bt_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [7:0] byte_in,
   input  logic       byte_vld,
   output logic       ok_pulse
);

   logic [1:0] progress;
   logic [7:0] expByte;

   // Byte expected at the current position in the sequence.
   always_comb begin
      expByte = BT_ASCII_O;
      case (progress)
         2'd0:    expByte = BT_ASCII_O;
         2'd1:    expByte = BT_ASCII_K;
         2'd2:    expByte = BT_ASCII_CR;
         default: expByte = BT_ASCII_LF;
      endcase
   end

   // Progress tracking; an 'O' on mismatch restarts the sequence at 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         progress <= 2'd0;
         ok_pulse <= 1'b0;
      end else begin
         ok_pulse <= 1'b0;
         if (clr) begin
            progress <= 2'd0;
         end else if (byte_vld) begin
            if (byte_in == expByte) begin
               if (progress == 2'd3) begin
                  progress <= 2'd0;
                  ok_pulse <= 1'b1;
               end else begin
                  progress <= progress + 2'd1;
               end
            end else if (byte_in == BT_ASCII_O) begin
               progress <= 2'd1;
            end else begin
               progress <= 2'd0;
            end
         end
      end
   end

endmodule

// File: rtl/bt_uart_rx.sv
// ---------------------------------------------------------------------------
// bt_uart_rx
// UART 8N1 receiver for the Bluetooth module's TX line. Delivers each byte
// with a one-cycle rx_valid strobe and flags bad stop bits with frame_err.
// Optional "OK\r\n" detection is built when BT_UART_RX_OK_MATCH_EN is
// defined; otherwise ok_pulse is tied low.
// Parameters:
//   CLKS_PER_BIT : clk cycles per UART bit (>= 4)
//   CNT_W        : bit-timing counter width, 2**CNT_W > CLKS_PER_BIT
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   init_flag    : receiver enable from the initializer
//   rxd          : asynchronous serial input, idles high
//   rx_data      : last correctly received byte
//   rx_valid     : one-cycle strobe, rx_data just updated
//   frame_err    : one-cycle strobe, stop bit sampled low
//   busy         : high whenever the FSM is not in IDLE
//   ok_pulse     : one-cycle strobe, "OK\r\n" completed (optional)
// ---------------------------------------------------------------------------
module bt_uart_rx
   import bt_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned CNT_W        = 13
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       init_flag,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy,
   output logic       ok_pulse
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic             rxMeta;
   logic             rxs;
   rxState_t         state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bitIdx;
   logic [7:0]       shiftReg;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxMeta <= 1'b1;
         rxs    <= 1'b1;
      end else begin
         rxMeta <= rxd;
         rxs    <= rxMeta;
      end
   end

   // Receiver FSM. Start bit is checked at its middle, after which every
   // sample lands a full bit later, i.e. mid-bit. The FSM leaves STOP at
   // the middle of the stop bit so a following start edge is never missed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bitIdx    <= 3'd0;
         shiftReg  <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (!init_flag) begin
            state  <= IDLE;
            cnt    <= '0;
            bitIdx <= 3'd0;
            busy   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (!rxs) begin
                     state <= START;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end
               end
               START: begin
                  if (cnt == HALF_LAST) begin
                     cnt <= '0;
                     if (!rxs) begin
                        state  <= DATA;
                        bitIdx <= 3'd0;
                     end else begin
                        // Low pulse shorter than half a bit: ignore.
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               DATA: begin
                  if (cnt == BIT_LAST) begin
                     cnt      <= '0;
                     shiftReg <= {rxs, shiftReg[7:1]};
                     if (bitIdx == 3'd7) begin
                        state <= STOP;
                     end else begin
                        bitIdx <= bitIdx + 3'd1;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               STOP: begin
                  if (cnt == BIT_LAST) begin
                     cnt   <= '0;
                     state <= IDLE;
                     busy  <= 1'b0;
                     if (rxs) begin
                        rx_data  <= shiftReg;
                        rx_valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef BT_UART_RX_OK_MATCH_EN
   // Acknowledgement detector fed by the registered byte strobe.
   bt_ok_matcher u_okMatcher (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (!init_flag || frame_err),
      .byte_in  (rx_data),
      .byte_vld (rx_valid),
      .ok_pulse (ok_pulse)
   );
`else
   assign ok_pulse = 1'b0;
`endif

endmodule
